// File: rtl/vend_controller.sv
// -----------------------------------------------------------------------------
// vend_controller
//   Vending FSM that sits directly downstream of the currency accumulator.
//
//   Credit is the running upstream total minus an internal "consumed" offset,
//   with all arithmetic taken mod 2^CURRENCY_WIDTH. Because of this, a wrap of
//   the upstream total has no visible effect. The upstream total is never
//   cleared; the offset simply catches up with it as products are dispensed
//   and change is paid out.
//
//   States: IDLE -> CREDIT -> CHECK -> DISPENSE -> (CHANGE) -> IDLE/CREDIT.
//   From CREDIT, a cancel or an idle timeout goes to CHANGE and refunds the
//   whole credit.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   total_currency[W], currency_avail
//                                 running sum from upstream, plus its update
//                                 pulse
//   select_valid, select_id[2]    selection strobe and product index
//                                 (sampled in CREDIT only)
//   cancel                        refund request (sampled in CREDIT only)
//   restock                       reloads stock counters (INVENTORY_EN only)
//   dispense_valid/id/ready       product handshake toward the actuator
//   change_valid/value/ready      change handshake toward the coin hopper
//   insufficient, sold_out        1-cycle result pulses of CHECK
//   credit[W]                     current credit (combinational)
//   busy                          high in CHECK, DISPENSE and CHANGE
//
// Configuration macro
//   INVENTORY_EN  enables the per-product stock counters, the sold_out pulse
//                 and restock. When undefined, stock is treated as infinite.
// -----------------------------------------------------------------------------
module vend_controller #(
  parameter int                          CURRENCY_WIDTH = 7,
  parameter logic [4*CURRENCY_WIDTH-1:0] PRICE_TABLE    = {7'd25, 7'd20, 7'd15, 7'd10},
  parameter int                          TIMEOUT_CYCLES = 1000,
  parameter int                          STOCK_INIT     = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CURRENCY_WIDTH-1:0] total_currency,
  input  logic                      currency_avail,
  input  logic                      select_valid,
  input  logic [1:0]                select_id,
  input  logic                      cancel,
  input  logic                      restock,
  output logic                      dispense_valid,
  output logic [1:0]                dispense_id,
  input  logic                      dispense_ready,
  output logic                      change_valid,
  output logic [CURRENCY_WIDTH-1:0] change_value,
  input  logic                      change_ready,
  output logic                      insufficient,
  output logic                      sold_out,
  output logic [CURRENCY_WIDTH-1:0] credit,
  output logic                      busy
);

  localparam int W       = CURRENCY_WIDTH;
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CREDIT   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [W-1:0]       consumed_r, consumed_s;
  logic [1:0]         sel_id_r, sel_id_s;
  logic [W-1:0]       change_r, change_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic               insufficient_r, insufficient_s;
  logic               sold_out_r, sold_out_s;
  logic [W-1:0]       price_s;
  logic [W-1:0]       credit_after_s;
  logic               stock_empty_s;

  // Price of product id, taken from the packed table (product k at bits [k*W +: W]).
  function automatic logic [W-1:0] price_of(input logic [1:0] id);
    price_of = PRICE_TABLE[int'(id)*W +: W];
  endfunction

  assign credit         = total_currency - consumed_r;
  assign price_s        = price_of(sel_id_r);
  assign dispense_valid = (state_r == ST_DISPENSE);
  assign dispense_id    = sel_id_r;
  assign change_valid   = (state_r == ST_CHANGE);
  assign change_value   = change_r;
  assign insufficient   = insufficient_r;
  assign sold_out       = sold_out_r;
  assign busy           = (state_r == ST_CHECK) || (state_r == ST_DISPENSE) ||
                          (state_r == ST_CHANGE);

`ifdef INVENTORY_EN
  localparam int STOCK_W = $clog2(STOCK_INIT + 1);

  logic [STOCK_W-1:0] stock_r [4];

  assign stock_empty_s = (stock_r[sel_id_r] == {STOCK_W{1'b0}});

  // Stock counters: reload on restock (except while dispensing), decrement on a dispense handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) stock_r[i] <= STOCK_W'(STOCK_INIT);
    end else if (restock && (state_r != ST_DISPENSE)) begin
      for (int i = 0; i < 4; i++) stock_r[i] <= STOCK_W'(STOCK_INIT);
    end else if ((state_r == ST_DISPENSE) && dispense_ready && !stock_empty_s) begin
      stock_r[sel_id_r] <= stock_r[sel_id_r] - STOCK_W'(1);
    end
  end
`else
  // Without inventory, stock is infinite and restock has no effect.
  localparam int unused_stock_init = STOCK_INIT;
  logic unused_restock;
  assign unused_restock = restock;
  assign stock_empty_s  = 1'b0;
`endif

  // Next-state, datapath and pulse logic.
  always_comb begin
    state_s        = state_r;
    consumed_s     = consumed_r;
    sel_id_s       = sel_id_r;
    change_s       = change_r;
    timer_s        = {TIMER_W{1'b0}};
    insufficient_s = 1'b0;
    sold_out_s     = 1'b0;
    credit_after_s = credit;
    case (state_r)
      ST_IDLE: begin
        if (credit != {W{1'b0}}) begin
          state_s = ST_CREDIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CREDIT: begin
        if (currency_avail) begin
          timer_s = {TIMER_W{1'b0}};
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
        // A selection wins over a cancel or timeout arriving in the same cycle.
        // A coin arriving in the timeout cycle restarts the count instead of refunding.
        if (select_valid) begin
          sel_id_s = select_id;
          state_s  = ST_CHECK;
        end else if (cancel ||
                     ((timer_r == TIMER_W'(TIMEOUT_CYCLES - 1)) && !currency_avail)) begin
          change_s = credit;
          state_s  = ST_CHANGE;
        end else begin
          state_s = ST_CREDIT;
        end
      end
      ST_CHECK: begin
        if (stock_empty_s) begin
          sold_out_s = 1'b1;
          state_s    = ST_CREDIT;
        end else if (price_s > credit) begin
          insufficient_s = 1'b1;
          state_s        = ST_CREDIT;
        end else begin
          state_s = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (dispense_ready) begin
          consumed_s     = consumed_r + price_s;
          credit_after_s = total_currency - consumed_s;
          change_s       = credit - price_s;
          if (change_s != {W{1'b0}}) begin
            state_s = ST_CHANGE;
          end else if (credit_after_s != {W{1'b0}}) begin
            state_s = ST_CREDIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DISPENSE;
        end
      end
      ST_CHANGE: begin
        if (change_ready) begin
          consumed_s     = consumed_r + change_r;
          credit_after_s = total_currency - consumed_s;
          change_s       = {W{1'b0}};
          if (credit_after_s != {W{1'b0}}) begin
            state_s = ST_CREDIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_CHANGE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r        <= ST_IDLE;
      consumed_r     <= {W{1'b0}};
      sel_id_r       <= 2'd0;
      change_r       <= {W{1'b0}};
      timer_r        <= {TIMER_W{1'b0}};
      insufficient_r <= 1'b0;
      sold_out_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      consumed_r     <= consumed_s;
      sel_id_r       <= sel_id_s;
      change_r       <= change_s;
      timer_r        <= timer_s;
      insufficient_r <= insufficient_s;
      sold_out_r     <= sold_out_s;
    end
  end

endmodule
